// File: rtl/img_row_window_buffer.sv
// Full-frame row store that emits K-row windows at a fixed row stride, overlapping load and drain.
// Optional zero padding above/below the frame: define IMG_ROW_WINDOW_BUFFER_ZERO_PAD_EN.

module img_row_window_tap #(
  parameter int DW    = 8,
  parameter int IMG_H = 28,
  parameter int IMG_W = 28,
  parameter int RW    = 5
) (
  input  logic [IMG_H-1:0][IMG_W-1:0][DW-1:0] frame,
  input  logic signed [31:0]                  row,
  output logic [IMG_W-1:0][DW-1:0]            data
);
  logic          in_range;
  logic [RW-1:0] idx;

  assign in_range = (row >= 0) && (row < IMG_H);
  assign idx      = in_range ? RW'(row) : '0;

`ifdef IMG_ROW_WINDOW_BUFFER_ZERO_PAD_EN
  assign data = in_range ? frame[idx] : '0;
`else
  assign data = frame[idx];
`endif
endmodule

module img_row_window_buffer #(
  parameter int DW     = 8,
  parameter int IMG_H  = 28,
  parameter int IMG_W  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int PAD    = 1,
`ifdef IMG_ROW_WINDOW_BUFFER_ZERO_PAD_EN
  localparam int P     = PAD,
`else
  localparam int P     = 0 * PAD,
`endif
  localparam int OH    = (IMG_H + 2 * P - K) / STRIDE + 1,
  localparam int IW    = $clog2(OH + 1)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_row_valid,
  output logic                              o_row_ready,
  input  logic [IMG_W-1:0][DW-1:0]          i_row_data,
  output logic                              o_win_valid,
  input  logic                              i_win_ready,
  output logic [K-1:0][IMG_W-1:0][DW-1:0]   o_win_data,
  output logic [IW-1:0]                     o_win_idx,
  output logic                              o_win_last,
  output logic                              o_busy
);
  localparam int WW = $clog2(IMG_H + 1);
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t                              state;
  logic [WW-1:0]                       wr_row, wr_nxt;
  logic [IW-1:0]                       win_cnt, win_nxt;
  logic [IMG_H-1:0][IMG_W-1:0][DW-1:0] frame;
  logic                                row_fire, win_fire, frame_end;
  logic signed [31:0]                  top, need;

  assign o_row_ready = (state == S_FILL);
  assign row_fire    = i_row_valid & o_row_ready;
  assign win_fire    = o_win_valid & i_win_ready;
  assign wr_nxt      = wr_row + WW'(row_fire);
  assign win_nxt     = win_cnt + IW'(win_fire);
  assign frame_end   = (wr_nxt == WW'(IMG_H)) && (win_nxt == IW'(OH));

  // Window rows run top..top+K-1; top goes negative only in the padded build.
  assign top  = $signed({{(32-IW){1'b0}}, win_cnt}) * STRIDE - P;
  assign need = (top + K > IMG_H) ? IMG_H : top + K;

  assign o_win_valid = (win_cnt < IW'(OH)) && ($signed({{(32-WW){1'b0}}, wr_row}) >= need);
  assign o_win_last  = o_win_valid && (win_cnt == IW'(OH - 1));
  assign o_win_idx   = win_cnt;
  assign o_busy      = (wr_row != '0) || (win_cnt != '0);

  for (genvar k = 0; k < K; k++) begin : g_tap
    img_row_window_tap #(.DW(DW), .IMG_H(IMG_H), .IMG_W(IMG_W), .RW(RW)) u_tap (
      .frame (frame),
      .row   (top + k),
      .data  (o_win_data[k])
    );
  end

  // Writes land at wr_row, always below the pending window, so held output data stays stable.
  always_ff @(posedge i_clk) begin
    if (row_fire) frame[RW'(wr_row)] <= i_row_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_FILL;
      wr_row  <= '0;
      win_cnt <= '0;
    end else if (frame_end) begin
      state   <= S_FILL;
      wr_row  <= '0;
      win_cnt <= '0;
    end else begin
      wr_row  <= wr_nxt;
      win_cnt <= win_nxt;
      if (wr_nxt == WW'(IMG_H)) state <= S_DRAIN;
    end
  end
endmodule

// File: tb/tb_img_row_window_buffer.sv
// Directed bench for img_row_window_buffer: default geometry (u0) and a STRIDE=2 instance (u1).
`timescale 1ns/1ps
module tb_img_row_window_buffer;
  localparam int DW = 8, IMG_H = 28, IMG_W = 28, K = 3;
`ifdef IMG_ROW_WINDOW_BUFFER_ZERO_PAD_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int OH0 = (IMG_H + 2 * P - K) / 1 + 1;
  localparam int OH1 = (IMG_H + 2 * P - K) / 2 + 1;

  typedef logic [IMG_W-1:0][DW-1:0]        row_t;
  typedef logic [K-1:0][IMG_W-1:0][DW-1:0] win_t;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic rv0 = 0, wr0 = 0, rr0, wv0, wl0, busy0;
  row_t rd0 = '0;
  win_t wd0;
  logic [$clog2(OH0+1)-1:0] wi0;
  logic rv1 = 0, wr1 = 0, rr1, wv1, wl1, busy1;
  row_t rd1 = '0;
  win_t wd1;
  logic [$clog2(OH1+1)-1:0] wi1;

  int checks = 0, failures = 0, fr = 0;
  string tname = "reset";

  img_row_window_buffer u0 (
    .i_clk(clk), .i_rst(rst), .i_row_valid(rv0), .o_row_ready(rr0), .i_row_data(rd0),
    .o_win_valid(wv0), .i_win_ready(wr0), .o_win_data(wd0), .o_win_idx(wi0),
    .o_win_last(wl0), .o_busy(busy0));

  img_row_window_buffer #(.STRIDE(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_row_valid(rv1), .o_row_ready(rr1), .i_row_data(rd1),
    .o_win_valid(wv1), .i_win_ready(wr1), .o_win_data(wd1), .o_win_idx(wi1),
    .o_win_last(wl1), .o_busy(busy1));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%0h exp=%0h", tname, tag, got, exp);
    end
  endtask

  // Frame 0 row r is all pixels = r; later frames vary per column too.
  function automatic row_t exp_row(input int f, input int r);
    row_t v = '0;
    if (r >= 0 && r < IMG_H)
      for (int c = 0; c < IMG_W; c++) v[c] = 8'(r + 40 * f + c * f);
    return v;
  endfunction

  function automatic bit exp_valid(input int mr, input int mw, input int s, input int oh);
    int need = mw * s - P + K;
    if (need > IMG_H) need = IMG_H;
    return (mw < oh) && (mr >= need);
  endfunction

  task automatic cyc_chk(input logic rr, input logic wv, input logic wl, input logic bz,
                         input logic [7:0] wi, input win_t wd,
                         input int mr, input int mw, input int s, input int oh, input int f);
    bit ev = exp_valid(mr, mw, s, oh);
    chk("rdy", rr, mr < IMG_H);
    chk("busy", bz, (mr != 0) || (mw != 0));
    chk("valid", wv, ev);
    if (ev && wv) begin
      chk("idx", wi, mw);
      chk("last", wl, mw == oh - 1);
      for (int k = 0; k < K; k++)
        chk($sformatf("w%0d_row%0d", mw, k), wd[k], exp_row(f, mw * s - P + k));
    end
  endtask

  // Drives u0 with valid/ready percentages; ready forced low for the first `hold` cycles.
  task automatic run0(input int frames, input int pv, input int pw, input int hold,
                      input int rcap, input int wcap, output bit ok);
    int mr = 0, mw = 0, done = 0;
    bit rf, wf;
    ok = 0;
    for (int cyc = 0; cyc < 3000 && !ok; cyc++) begin
      rv0 = (mr < rcap) && ($urandom_range(99) < pv);
      wr0 = (mw < wcap) && (cyc >= hold) && ($urandom_range(99) < pw);
      rd0 = exp_row(fr, mr);
      #1;
      cyc_chk(rr0, wv0, wl0, busy0, 8'(wi0), wd0, mr, mw, 1, OH0, fr);
      rf = rv0 & rr0;
      wf = wv0 & wr0;
      @(posedge clk);
      mr += int'(rf);
      mw += int'(wf);
      if (mr == IMG_H && mw == OH0) begin
        mr = 0; mw = 0; fr++; done++;
      end
      @(negedge clk);
      ok = (done >= frames) || (mr >= rcap && mw >= wcap);
    end
    rv0 = 0;
    wr0 = 0;
  endtask

  initial begin
    bit ok, rf, wf;
    int m1r, m1w;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rdy0", rr0, 1);
    chk("valid0", wv0, 0);
    chk("last0", wl0, 0);
    chk("idx0", wi0, 0);
    chk("busy0", busy0, 0);
    chk("rdy1", rr1, 1);
    chk("busy1", busy1, 0);
    @(negedge clk);

    tname = "stride2";
    m1r = 0; m1w = 0; ok = 0;
    for (int cyc = 0; cyc < 200 && !ok; cyc++) begin
      rv1 = (m1r < IMG_H) && !(P == 0 && m1r == IMG_H - 1 && m1w < OH1);
      wr1 = 1;
      rd1 = exp_row(0, m1r);
      #1;
      cyc_chk(rr1, wv1, wl1, busy1, 8'(wi1), wd1, m1r, m1w, 2, OH1, 0);
      if (rv1 && m1r == IMG_H - 1) chk("lastrow_valid", wv1, 0);
      rf = rv1 & rr1;
      wf = wv1 & wr1;
      @(posedge clk);
      m1r += int'(rf);
      m1w += int'(wf);
      if (m1r == IMG_H && m1w == OH1) ok = 1;
      @(negedge clk);
    end
    chk("done", ok, 1);
    rv1 = 0;
    wr1 = 0;
    #1;
    chk("busy_after", busy1, 0);
    chk("rdy_after", rr1, 1);
    @(negedge clk);

    tname = "default";
    run0(1, 100, 100, 0, 999, 999, ok);
    chk("done", ok, 1);
    tname = "hold";
    run0(1, 100, 100, 40, 999, 999, ok);
    chk("done", ok, 1);
    tname = "random";
    run0(3, 60, 60, 0, 999, 999, ok);
    chk("done", ok, 1);

    tname = "rst_mid";
    run0(1, 100, 100, 0, 10, 5, ok);
    chk("stop", ok, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("valid", wv0, 0);
    chk("busy", busy0, 0);
    @(negedge clk);
    rst = 0;
    fr = 0;
    tname = "after_rst";
    run0(1, 100, 100, 0, 999, 999, ok);
    chk("done", ok, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
